camera_capture_mf: RTL and testbench

- Parametrised multi-frame capture block for a DVP-style camera (8-bit `data`, `href`, `vsync`).
- Packs incoming bytes into `BUS_W`-bit words and writes them into a ring of `NUM_FRAMES` frame buffers in DDR.
- Presents each word with its DDR address over a valid/ready handshake, counts rows, and issues the once-per-frame HDR exposure-change pulse.
- Captures only complete frames and optionally rejects frames with the wrong length.

---
 rtl/camera_capture_pkg.sv | 32 +++
 rtl/camera_capture_mf_byte_packer.sv | 39 +++
 rtl/camera_capture_mf.sv | 171 +++++++++++++++++
 tb/tb_camera_capture_mf.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/camera_capture_pkg.sv
// Shared types and derived-geometry helpers for the multi-frame camera capture block.
package camera_capture_pkg;

    typedef enum logic [1:0] {
        SYNC,
        IDLE,
        CAPTURE
    } state_t;

    function automatic int unsigned frame_words(
        input int unsigned rows,
        input int unsigned row_bytes,
        input int unsigned bus_w
    );
        return rows * row_bytes * 8 / bus_w;
    endfunction

    function automatic int unsigned frame_stride(
        input int unsigned words,
        input int unsigned inc
    );
        return words * inc;
    endfunction

    function automatic int unsigned base_addr(
        input int unsigned idx,
        input int unsigned stride
    );
        return idx * stride;
    endfunction

endpackage

// File: rtl/camera_capture_mf_byte_packer.sv
// Byte lane counter and word assembly; word_done is combinational with the last
// byte so the parent can load its output register on that same edge.
module byte_packer
    import camera_capture_pkg::*;
#(
    parameter int BUS_W = 128
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    input  logic [7:0]       data,
    output logic [BUS_W-1:0] word,
    output logic             word_done
);

    localparam int LANES  = BUS_W / 8;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    logic [LANE_W-1:0] lane;
    logic [BUS_W-1:0]  acc;

    always_ff @(posedge clk) begin
        if (clear) begin
            lane <= '0;
            acc  <= '0;
        end else if (en) begin
            acc[lane*8 +: 8] <= data;
            lane <= word_done ? '0 : lane + 1'b1;
        end
    end

    // The final byte bypasses acc so the full word is ready on the sampling edge.
    always_comb begin
        word             = acc;
        word[lane*8 +: 8] = data;
        word_done        = en && (lane == LANE_W'(LANES - 1));
    end

endmodule

// File: rtl/camera_capture_mf.sv
// DVP multi-frame capture into a DDR ring of frame buffers.
// Define CAMERA_CAPTURE_FRAME_CHECK_EN to enable the frame length check.
module camera_capture_mf
    import camera_capture_pkg::*;
#(
    parameter int BUS_W      = 128,
    parameter int ADDR_W     = 25,
    parameter int ADDR_INC   = 4,
    parameter int NUM_FRAMES = 6,
    parameter int ROWS       = 480,
    parameter int ROW_BYTES  = 1280,
    parameter int EXP_ROW    = 480
) (
    input  logic              p_clk,
    input  logic              rst,
    input  logic [7:0]        data,
    input  logic              href,
    input  logic              vsync,
    input  logic              take_pic,
    input  logic              hdr_en,
    input  logic              wr_ready,
    output logic [BUS_W-1:0]  p_data,
    output logic              data_valid,
    output logic [ADDR_W-1:0] wr_address,
    output logic [2:0]        last_frame,
    output logic              frame_done,
    output logic              change_exp,
    output logic              frame_err,
    output logic              overflow
);

    localparam int unsigned FRAME_WORDS  = frame_words(ROWS, ROW_BYTES, BUS_W);
    localparam int unsigned FRAME_STRIDE = frame_stride(FRAME_WORDS, ADDR_INC);
    localparam int          ROW_W        = $clog2(ROWS + 1) + 1;

`ifdef CAMERA_CAPTURE_FRAME_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    state_t state, state_next;

    logic              restart;
    logic              q_vsync, q_href;
    logic              vs_rise, vs_fall, href_fall;
    logic              cap_start, cap_end;
    logic              byte_en;
    logic [BUS_W-1:0]  word;
    logic              word_done;
    logic [ADDR_W-1:0] word_idx;
    logic [ADDR_W-1:0] base;
    logic [ROW_W-1:0]  row_cnt;
    logic              exp_pending;
    logic              at_limit, good;

    assign restart   = rst || take_pic;
    assign vs_rise   = vsync && !q_vsync;
    assign vs_fall   = q_vsync && !vsync;
    assign href_fall = q_href && !href;
    assign byte_en   = (state == CAPTURE) && href;

    assign at_limit = CHECK_EN && (word_idx == ADDR_W'(FRAME_WORDS));
    assign good     = !CHECK_EN || (word_idx == ADDR_W'(FRAME_WORDS));

    byte_packer #(
        .BUS_W(BUS_W)
    ) u_packer (
        .clk      (p_clk),
        .clear    (restart || cap_start),
        .en       (byte_en),
        .data     (data),
        .word     (word),
        .word_done(word_done)
    );

    always_ff @(posedge p_clk) begin
        if (restart) begin
            state   <= SYNC;
            q_vsync <= 1'b0;
            q_href  <= 1'b0;
        end else begin
            state   <= state_next;
            q_vsync <= vsync;
            q_href  <= href;
        end
    end

    always_comb begin
        state_next = state;
        cap_start  = 1'b0;
        cap_end    = 1'b0;
        unique case (state)
            SYNC: begin
                if (vsync) state_next = IDLE;
            end
            IDLE: begin
                if (vs_fall) begin
                    state_next = CAPTURE;
                    cap_start  = 1'b1;
                end
            end
            CAPTURE: begin
                if (vs_rise) begin
                    state_next = IDLE;
                    cap_end    = 1'b1;
                end
            end
            default: state_next = SYNC;
        endcase
    end

    always_ff @(posedge p_clk) begin
        if (restart) begin
            p_data      <= '0;
            wr_address  <= '0;
            data_valid  <= 1'b0;
            frame_done  <= 1'b0;
            change_exp  <= 1'b0;
            frame_err   <= 1'b0;
            overflow    <= 1'b0;
            word_idx    <= '0;
            base        <= '0;
            row_cnt     <= '0;
            exp_pending <= 1'b0;
            if (rst) last_frame <= '0;
        end else begin
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            change_exp <= 1'b0;

            if (cap_start) begin
                word_idx    <= '0;
                row_cnt     <= '0;
                base        <= ADDR_W'(base_addr(32'(last_frame), FRAME_STRIDE));
                exp_pending <= hdr_en;
            end

            if (state == CAPTURE && href_fall) row_cnt <= row_cnt + 1'b1;

            if (state == CAPTURE && exp_pending && row_cnt == ROW_W'(EXP_ROW)) begin
                change_exp  <= 1'b1;
                exp_pending <= 1'b0;
            end

            if (data_valid && wr_ready) data_valid <= 1'b0;

            // Dropped words still advance word_idx so later addresses stay in place.
            if (word_done && !at_limit) begin
                word_idx <= word_idx + 1'b1;
                if (data_valid && !wr_ready) begin
                    overflow <= 1'b1;
                end else begin
                    p_data     <= word;
                    wr_address <= base + ADDR_W'(word_idx * ADDR_W'(ADDR_INC));
                    data_valid <= 1'b1;
                end
            end

            if (cap_end) begin
                if (good) begin
                    frame_done <= 1'b1;
                    last_frame <= (last_frame == 3'(NUM_FRAMES - 1)) ? '0 : last_frame + 3'd1;
                end else begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_camera_capture_mf.sv
// Scoreboard bench for camera_capture_mf with small 3x32-byte frames.
module tb_camera_capture_mf;

    localparam int BUS_W      = 128;
    localparam int ADDR_W     = 25;
    localparam int ADDR_INC   = 4;
    localparam int NUM_FRAMES = 6;
    localparam int ROWS       = 3;
    localparam int ROW_BYTES  = 32;
    localparam int EXP_ROW    = 2;
    localparam int LANES      = BUS_W / 8;
    localparam int FW         = ROWS * ROW_BYTES / LANES;
    localparam int STRIDE     = FW * ADDR_INC;

`ifdef CAMERA_CAPTURE_FRAME_CHECK_EN
    localparam bit CHECK = 1'b1;
`else
    localparam bit CHECK = 1'b0;
`endif

    logic              p_clk = 1'b0;
    logic              rst;
    logic [7:0]        data;
    logic              href;
    logic              vsync;
    logic              take_pic;
    logic              hdr_en;
    logic              wr_ready;
    logic [BUS_W-1:0]  p_data;
    logic              data_valid;
    logic [ADDR_W-1:0] wr_address;
    logic [2:0]        last_frame;
    logic              frame_done;
    logic              change_exp;
    logic              frame_err;
    logic              overflow;

    camera_capture_mf #(
        .BUS_W     (BUS_W),
        .ADDR_W    (ADDR_W),
        .ADDR_INC  (ADDR_INC),
        .NUM_FRAMES(NUM_FRAMES),
        .ROWS      (ROWS),
        .ROW_BYTES (ROW_BYTES),
        .EXP_ROW   (EXP_ROW)
    ) dut (
        .p_clk     (p_clk),
        .rst       (rst),
        .data      (data),
        .href      (href),
        .vsync     (vsync),
        .take_pic  (take_pic),
        .hdr_en    (hdr_en),
        .wr_ready  (wr_ready),
        .p_data    (p_data),
        .data_valid(data_valid),
        .wr_address(wr_address),
        .last_frame(last_frame),
        .frame_done(frame_done),
        .change_exp(change_exp),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    always #5 p_clk = ~p_clk;

    typedef struct packed {
        logic [BUS_W-1:0]  d;
        logic [ADDR_W-1:0] a;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    always @(posedge p_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [BUS_W-1:0] got,
                         input logic [BUS_W-1:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, got, want);
    endtask

    // Monitor: pulse counters, hold stability and in-order scoreboard pops.
    int done_cnt = 0, err_cnt = 0, exp_cnt = 0, exp_cyc = 0;
    int skipped = 0, skip_budget = 0;
    bit held = 1'b0;
    logic [BUS_W-1:0]  held_d;
    logic [ADDR_W-1:0] held_a;

    always @(negedge p_clk) begin
        if (!rst) begin
            if (frame_done) done_cnt++;
            if (frame_err) err_cnt++;
            if (change_exp) begin
                exp_cnt++;
                exp_cyc = cyc;
            end
            if (held) begin
                check("hold_valid", BUS_W'(data_valid), BUS_W'(1));
                check("hold_data", p_data, held_d);
                check("hold_addr", BUS_W'(wr_address), BUS_W'(held_a));
            end
            if (data_valid && wr_ready) begin
                while (skipped < skip_budget && sbq.size() > 0 && sbq[0].a != wr_address) begin
                    void'(sbq.pop_front());
                    skipped++;
                end
                if (sbq.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_word: got addr %0h data %0h want none",
                             wr_address, p_data);
                end else begin
                    mon_e = sbq.pop_front();
                    check("word_data", p_data, mon_e.d);
                    check("word_addr", BUS_W'(wr_address), BUS_W'(mon_e.a));
                end
            end
            held   = data_valid && !wr_ready && !take_pic;
            held_d = p_data;
            held_a = wr_address;
        end else begin
            held = 1'b0;
        end
    end

    // Downstream ready: random short stalls, or a forced stall window.
    int hold_until = 0;
    initial begin
        int lowrun;
        lowrun = 0;
        wr_ready = 1'b1;
        forever begin
            @(posedge p_clk);
            #1;
            if (cyc < hold_until) begin
                wr_ready = 1'b0;
                lowrun = 0;
            end else if (lowrun < 3 && $urandom_range(0, 3) == 0) begin
                wr_ready = 1'b0;
                lowrun++;
            end else begin
                wr_ready = 1'b1;
                lowrun = 0;
            end
        end
    end

    // Reference model: frame slot ring and byte stream -> expected words.
    int m_slot, m_base, m_widx, m_nb, m_rows, m_fall_cyc;
    logic [BUS_W-1:0] m_acc;
    int d0, e0, x0;

    task automatic tick();
        @(posedge p_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit cap);
        exp_t t;
        tick();
        href = 1'b1;
        data = b;
        if (cap) begin
            m_acc[m_nb*8 +: 8] = b;
            m_nb++;
            if (m_nb == LANES) begin
                if (!CHECK || m_widx < FW) begin
                    t.d = m_acc;
                    t.a = ADDR_W'(m_base + m_widx * ADDR_INC);
                    sbq.push_back(t);
                end
                m_widx++;
                m_nb = 0;
            end
        end
    endtask

    task automatic send_row(input int n, input bit cap, input bit incr);
        for (int i = 0; i < n; i++) begin
            logic [7:0] b;
            b = incr ? 8'(m_widx * LANES + m_nb) : 8'($urandom);
            send_byte(b, cap);
        end
        tick();
        href = 1'b0;
        if (cap) begin
            m_rows++;
            if (m_rows == EXP_ROW) m_fall_cyc = cyc;
        end
        repeat (3) tick();
    endtask

    task automatic frame_begin(input bit hdr);
        tick();
        vsync = 1'b1;
        hdr_en = hdr;
        repeat (3) tick();
        vsync = 1'b0;
        m_base = m_slot * STRIDE;
        m_widx = 0;
        m_nb = 0;
        m_rows = 0;
        d0 = done_cnt;
        e0 = err_cnt;
        x0 = exp_cnt;
        repeat (3) tick();
    endtask

    task automatic frame_end(input bit hdr);
        bit good;
        repeat (2) tick();
        vsync = 1'b1;
        repeat (5) tick();
        @(negedge p_clk);
        good = !CHECK || (m_widx == FW);
        check("queue_empty", BUS_W'(sbq.size()), BUS_W'(0));
        check("frame_done_count", BUS_W'(done_cnt - d0), BUS_W'(good));
        check("frame_err_count", BUS_W'(err_cnt - e0), BUS_W'(!good));
        if (good) m_slot = (m_slot + 1) % NUM_FRAMES;
        check("last_frame", BUS_W'(last_frame), BUS_W'(m_slot));
        check("change_exp_count", BUS_W'(exp_cnt - x0), BUS_W'(hdr));
        if (hdr) check("change_exp_cycle", BUS_W'(exp_cyc), BUS_W'(m_fall_cyc + 2));
    endtask

    task automatic full_frame(input bit hdr, input bit incr);
        frame_begin(hdr);
        for (int r = 0; r < ROWS; r++) send_row(ROW_BYTES, 1'b1, incr);
        frame_end(hdr);
    endtask

    initial begin
        bit h;
        rst = 1'b1;
        take_pic = 1'b0;
        hdr_en = 1'b0;
        vsync = 1'b0;
        href = 1'b0;
        data = 8'h00;
        m_slot = 0;
        m_acc = '0;

        // Reset lands in the middle of a frame already in progress.
        send_row(10, 1'b0, 1'b0);
        @(negedge p_clk);
        check("rst_data_valid", BUS_W'(data_valid), BUS_W'(0));
        check("rst_p_data", p_data, BUS_W'(0));
        check("rst_wr_address", BUS_W'(wr_address), BUS_W'(0));
        check("rst_last_frame", BUS_W'(last_frame), BUS_W'(0));
        check("rst_overflow", BUS_W'(overflow), BUS_W'(0));
        check("rst_pulses", BUS_W'({frame_done, frame_err, change_exp}), BUS_W'(0));
        tick();
        rst = 1'b0;
        send_row(ROW_BYTES, 1'b0, 1'b0);
        send_row(ROW_BYTES, 1'b0, 1'b0);

        full_frame(1'b1, 1'b1);
        full_frame(1'b0, 1'b0);

        // Restart mid-word while filling buffer 2.
        frame_begin(1'b1);
        send_row(ROW_BYTES, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) send_byte(8'($urandom), 1'b1);
        tick();
        take_pic = 1'b1;
        tick();
        take_pic = 1'b0;
        @(negedge p_clk);
        check("take_pic_valid", BUS_W'(data_valid), BUS_W'(0));
        check("take_pic_last_frame", BUS_W'(last_frame), BUS_W'(2));
        check("take_pic_overflow", BUS_W'(overflow), BUS_W'(0));
        send_row(24, 1'b0, 1'b0);
        send_row(ROW_BYTES, 1'b0, 1'b0);
        tick();
        vsync = 1'b1;
        repeat (5) tick();
        @(negedge p_clk);
        check("take_pic_no_done", BUS_W'(done_cnt - d0), BUS_W'(0));
        check("take_pic_queue", BUS_W'(sbq.size()), BUS_W'(0));
        check("take_pic_no_exp", BUS_W'(exp_cnt - x0), BUS_W'(0));

        // Buffers 2..5, wrap, then buffer 0 again.
        for (int f = 0; f < 5; f++) begin
            h = 1'($urandom_range(0, 1));
            full_frame(h, 1'b0);
        end
        @(negedge p_clk);
        check("overflow_clear", BUS_W'(overflow), BUS_W'(0));

        // Long stall spanning two word completions.
        frame_begin(1'b0);
        skip_budget = 1;
        hold_until = cyc + 40;
        for (int r = 0; r < ROWS; r++) send_row(ROW_BYTES, 1'b1, 1'b0);
        frame_end(1'b0);
        check("dropped_words", BUS_W'(skipped), BUS_W'(1));
        check("overflow_set", BUS_W'(overflow), BUS_W'(1));

        // Short frame of 5 words.
        h = 1'($urandom_range(0, 1));
        frame_begin(h);
        send_row(ROW_BYTES, 1'b1, 1'b0);
        send_row(ROW_BYTES, 1'b1, 1'b0);
        send_row(ROW_BYTES / 2, 1'b1, 1'b0);
        frame_end(h);

        for (int f = 0; f < 3; f++) begin
            h = 1'($urandom_range(0, 1));
            full_frame(h, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
